// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage for the LoongArch32 core. It waits for variable-latency data
// SRAM responses, buffers one early response, extracts sub-word loads, and drops
// responses that belong to flushed loads.
module mem_stage_lsu #(
    parameter int XLEN     = 32,
    parameter int RF_AW    = 5,
    parameter int CANCEL_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             ws_allowin,
    output logic             ms_allowin,
    input  logic             es_to_ms_valid,
    input  logic [31:0]      es_pc,
    input  logic             es_gr_we,
    input  logic [RF_AW-1:0] es_dest,
    input  logic [XLEN-1:0]  es_alu_result,
    input  logic [2:0]       es_ld_op,
    input  logic             data_sram_data_ok,
    input  logic [XLEN-1:0]  data_sram_rdata,
    output logic             ms_to_ws_valid,
    output logic [31:0]      ms_pc,
    output logic             ms_gr_we,
    output logic [RF_AW-1:0] ms_dest,
    output logic [XLEN-1:0]  ms_final_result,
    output logic [RF_AW-1:0] ms_fwd_dest,
    output logic [XLEN-1:0]  ms_fwd_data,
    output logic             ms_fwd_stall
);

    localparam int OFF_W = $clog2(XLEN / 8);

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_B    = 3'd1;
    localparam logic [2:0] LD_BU   = 3'd2;
    localparam logic [2:0] LD_H    = 3'd3;
    localparam logic [2:0] LD_HU   = 3'd4;
    localparam logic [2:0] LD_W    = 3'd5;
    localparam logic [2:0] LD_WU   = 3'd6;
    localparam logic [2:0] LD_D    = 3'd7;

    localparam logic [CANCEL_W-1:0] CNT_MAX   = '1;
    localparam logic [OFF_W-1:0]    HALF_MASK = ~(OFF_W'(1));
    localparam logic [OFF_W-1:0]    WORD_MASK = ~(OFF_W'(3));

    logic                ms_valid;
    logic [XLEN-1:0]     ms_alu_result;
    logic [2:0]          ms_ld_op;
    logic                buf_valid;
    logic [XLEN-1:0]     buf_data;
    logic [CANCEL_W-1:0] discard_cnt;

    logic            is_load;
    logic            resp_live;
    logic            ms_ready_go;
    logic            ms_leave;
    logic            buf_fill;
    logic            discard_inc;
    logic            discard_dec;
    logic [OFF_W-1:0] byte_off;
    logic [XLEN-1:0] ld_src;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_word;

    // A response only belongs to the current load once all cancelled responses are drained.
    assign is_load     = (ms_ld_op != LD_NONE);
    assign resp_live   = data_sram_data_ok && (discard_cnt == '0);
    assign ms_ready_go = !is_load || buf_valid || resp_live;
    assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_leave    = ms_valid && ms_ready_go && ws_allowin;
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;

    assign buf_fill    = ms_valid && is_load && resp_live && !buf_valid && !ws_allowin && !flush;
    assign discard_dec = data_sram_data_ok && (discard_cnt != '0);
    assign discard_inc = flush && ms_valid && is_load && !ms_ready_go;

    assign byte_off = ms_alu_result[OFF_W-1:0];
    assign ld_src   = buf_valid ? buf_data : data_sram_rdata;
    assign ld_byte  = 8'(ld_src >> {byte_off, 3'b000});
    assign ld_half  = 16'(ld_src >> {byte_off & HALF_MASK, 3'b000});
    assign ld_word  = 32'(ld_src >> {byte_off & WORD_MASK, 3'b000});

    always_comb begin
        ms_final_result = ms_alu_result;
        case (ms_ld_op)
            LD_B:    ms_final_result = XLEN'(signed'(ld_byte));
            LD_BU:   ms_final_result = XLEN'(ld_byte);
            LD_H:    ms_final_result = XLEN'(signed'(ld_half));
            LD_HU:   ms_final_result = XLEN'(ld_half);
            LD_W:    ms_final_result = XLEN'(signed'(ld_word));
            LD_WU:   ms_final_result = XLEN'(ld_word);
            LD_D:    ms_final_result = ld_src;
            default: ms_final_result = ms_alu_result;
        endcase
    end

    assign ms_fwd_data  = ms_final_result;
    assign ms_fwd_dest  = ms_dest & {RF_AW{ms_valid & ms_gr_we}};
    assign ms_fwd_stall = ms_valid && is_load && !ms_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid      <= 1'b0;
            ms_pc         <= '0;
            ms_gr_we      <= 1'b0;
            ms_dest       <= '0;
            ms_alu_result <= '0;
            ms_ld_op      <= LD_NONE;
        end else begin
            if (flush) begin
                ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            if (es_to_ms_valid && ms_allowin && !flush) begin
                ms_pc         <= es_pc;
                ms_gr_we      <= es_gr_we;
                ms_dest       <= es_dest;
                ms_alu_result <= es_alu_result;
                ms_ld_op      <= es_ld_op;
            end
        end
    end

    // One-entry holding register for a response that arrives while WB is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else if (flush || ms_leave) begin
            buf_valid <= 1'b0;
        end else if (buf_fill) begin
            buf_valid <= 1'b1;
            buf_data  <= data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            discard_cnt <= '0;
        end else if (discard_inc && !discard_dec) begin
            if (discard_cnt != CNT_MAX) begin
                discard_cnt <= discard_cnt + 1'b1;
            end
        end else if (discard_dec && !discard_inc) begin
            discard_cnt <= discard_cnt - 1'b1;
        end
    end

    discard_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(discard_inc && !discard_dec && discard_cnt == CNT_MAX));

endmodule
